// File: rtl/rv_pkg.sv
// Shared RV32I definitions: widths, opcodes, funct3 codes
// and the ALU operation encoding used by data_path and rv_alu.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I ALU.
// Shift amount is taken from the low 5 bits of operand b.
module rv_alu
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] y
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // Select the operation result
    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Single-cycle RV32I integer datapath: register file,
// decoder, immediate generation, ALU and writeback.
module data_path
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instruction_word,
    output logic [XLEN-1:0] Addition_result
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    logic            valid;
    logic            use_imm;
    logic            is_lui;
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;

    assign opcode = instruction_word[6:0];
    assign rd     = instruction_word[11:7];
    assign funct3 = instruction_word[14:12];
    assign rs1    = instruction_word[19:15];
    assign rs2    = instruction_word[24:20];
    assign funct7 = instruction_word[31:25];

    assign imm_i = {{(XLEN-12){instruction_word[31]}},
                    instruction_word[31:20]};
    assign imm_u = {instruction_word[31:12], 12'b0};

    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    // Decode opcode/funct fields into an ALU op and operand selects
    always_comb begin
        valid   = 1'b0;
        use_imm = 1'b0;
        is_lui  = 1'b0;
        alu_op  = ALU_ADD;
        unique case (opcode)
            OP: begin
                if (funct7 == F7_BASE) begin
                    valid = 1'b1;
                    unique case (funct3)
                        F3_ADD:  alu_op = ALU_ADD;
                        F3_SLL:  alu_op = ALU_SLL;
                        F3_SLT:  alu_op = ALU_SLT;
                        F3_SLTU: alu_op = ALU_SLTU;
                        F3_XOR:  alu_op = ALU_XOR;
                        F3_SR:   alu_op = ALU_SRL;
                        F3_OR:   alu_op = ALU_OR;
                        F3_AND:  alu_op = ALU_AND;
                        default: alu_op = ALU_ADD;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    // Only SUB and SRA use the alternate funct7
                    if (funct3 == F3_ADD) begin
                        valid  = 1'b1;
                        alu_op = ALU_SUB;
                    end else if (funct3 == F3_SR) begin
                        valid  = 1'b1;
                        alu_op = ALU_SRA;
                    end
                end
            end
            OP_IMM: begin
                valid   = 1'b1;
                use_imm = 1'b1;
                unique case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLL:  alu_op = ALU_SLL;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            LUI: begin
                valid  = 1'b1;
                is_lui = 1'b1;
                alu_op = ALU_ADD;
            end
            default: valid = 1'b0;
        endcase
    end

    // Operand muxing: LUI adds the U-immediate to zero
    always_comb begin
        alu_a = is_lui ? '0 : rs1_val;
        alu_b = rs2_val;
        if (is_lui) begin
            alu_b = imm_u;
        end else if (use_imm) begin
            alu_b = imm_i;
        end
    end

    rv_alu u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    assign Addition_result = (rst && valid) ? alu_y : '0;

    // Next register file contents: write rd unless it is x0
    always_comb begin
        rf_d = rf_q;
        if (valid && rd != 5'd0) begin
            rf_d[rd] = alu_y;
        end
    end

    // Register file state with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_data_path;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_word;
    logic [31:0] Addition_result;

    int tests;
    int fails;

    data_path dut (
        .clk              (clk),
        .rst              (rst),
        .instruction_word (instruction_word),
        .Addition_result  (Addition_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [31:0] iw,
                        input logic [31:0] exp, input string tag);
        @(negedge clk);
        rst = r;
        instruction_word = iw;
        #1;
        tests++;
        assert (Addition_result === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h",
                   tag, Addition_result, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        instruction_word = 32'h0;

        step(1'b0, 32'h00108133, 32'h0, "reset_forced0");
        step(1'b0, 32'h00108133, 32'h0, "reset_forced1");
        step(1'b1, 32'h00108133, 32'h0, "regs_cleared");

        step(1'b1, 32'h00107093, 32'h0, "andi_x1_zero");
        step(1'b1, 32'h00100033, 32'h0, "add_x0_no_write");

        step(1'b1, 32'h00500093, 32'h5, "addi_x1_5");
        step(1'b1, 32'h00108133, 32'hA, "add_dep_x2");

        step(1'b1, 32'hFF800193, 32'hFFFFFFF8, "addi_neg8");
        step(1'b1, 32'h4011D213, 32'hFFFFFFFC, "srai_sign");

        step(1'b1, 32'h00700013, 32'h7, "addi_x0_7");
        step(1'b1, 32'h000002B3, 32'h0, "x0_protected");

        step(1'b1, 32'h40208333, 32'hFFFFFFFB, "sub_wrap");
        step(1'b1, 32'h0011A3B3, 32'h1, "slt_signed");
        step(1'b1, 32'h0011B3B3, 32'h0, "sltu_unsigned");
        step(1'b1, 32'h0011D433, 32'h07FFFFFF, "srl_zero_fill");
        step(1'b1, 32'h001096B3, 32'h000000A0, "sll");
        step(1'b1, 32'h123454B7, 32'h12345000, "lui");
        step(1'b1, 32'hFFF0C513, 32'hFFFFFFFA, "xori_neg1");
        step(1'b1, 32'h022085B3, 32'h0, "bad_funct7");

        step(1'b1, 32'h00500093, 32'h5, "reload_x1");
        step(1'b0, 32'h00500093, 32'h0, "midrun_reset");
        step(1'b1, 32'h00108133, 32'h0, "after_midrun");
        step(1'b1, 32'h00000000, 32'h0, "unsupported_op");
        step(1'b1, 32'h0011D433, 32'h0, "x3_cleared");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Single-cycle RV32I integer datapath for the RISC-V CPU: register file, decoder, immediate generator and ALU.
- The instruction is supplied externally on `instruction_word`; there is no internal PC or instruction memory.
- Each cycle it decodes the instruction, drives the ALU result on `Addition_result`, and writes it back to `rd` on the next rising clock edge.

Parameters:
- XLEN, 32, datapath/register width (only 32 supported).
- NREG, 32, number of architectural registers.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- instruction_word  input  32  RV32I instruction executed this cycle.
- Addition_result  output  32  combinational ALU result of the current instruction.

Behaviour:
- Register file: 32 x 32 bits; x0 reads 0 always and writes to it are discarded. Two combinational read ports (rs1 = [19:15], rs2 = [24:20]) and one synchronous write port (rd = [11:7]).
- Reset: on a rising edge with rst==0, all registers are cleared to 0 and no writeback occurs. While rst==0, Addition_result is forced to 0. Asserting reset mid-stream clears state at the next edge, regardless of the instruction.
- Decode on opcode [6:0]:
  - 0110011 (R-type): funct3/funct7[5] select ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - 0010011 (I-type ALU): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (funct7[5] distinguishes SRAI).
  - 0110111 (LUI): result = {imm[31:12], 12'b0}.
- I-immediate = sign-extended instruction_word[31:20]. Shift amount = low 5 bits of operand B.
- Arithmetic: add/sub wrap modulo 2^32 with no overflow flag. SLT is signed, SLTU unsigned; both yield 0 or 1. SRA sign-fills.
- Latency: Addition_result is valid combinationally in the same cycle as instruction_word. The register write lands at the next rising edge, so a dependent instruction presented the following cycle sees the new value. No bypass is needed.
- Unsupported opcode (including all-zero): Addition_result = 0, no register write.
- R-type encodings with funct7 other than 0000000/0100000: treated as unsupported.
- No handshake. One instruction per cycle; the instruction must be stable around the rising edge.

Decomposition:
- Shared package `rv_pkg`: opcode constants (OP, OP_IMM, LUI), funct3 codes, an ALU-op enum, and XLEN.
- One natural sub-module, `rv_alu`: combinational, operands a, b and an alu_op, producing the result. The register file and decoder stay inline in data_path.

Test Plan:
- Reset: rst=0 for 2 cycles, instr 0x00108133 -> Addition_result=0. After release, the same instruction -> 0, so all registers were cleared.
- ANDI x1,x0,1 (0x00107093) -> result 0 and x1 remains 0. Then ADD x0,x0,x1 (0x00100033) -> result 0, no write.
- ADDI x1,x0,5 (0x00500093) -> 5. Next cycle ADD x2,x1,x1 (0x00108133) -> 10, confirming writeback and a back-to-back dependency.
- ADDI x3,x0,-8 (0xFF800193) -> 0xFFFFFFF8. Then SRAI x4,x3,1 (0x4011D213) -> 0xFFFFFFFC, confirming sign-extension and arithmetic shift.
- x0 protection: ADDI x0,x0,7 (0x00700013) -> result 7. Then ADD x5,x0,x0 (0x000002B3) -> 0.
- Mid-run reset: load x1=5, assert rst=0 for one edge, release, then ADD x2,x1,x1 (0x00108133) -> 0. An unsupported opcode (0x00000000) -> 0 with no register change.
